dmem_port_arbiter: RTL and testbench
====================================

# dmem_port_arbiter

Two-port arbiter and access sequencer in front of `data_scratchpad`. It shares the single scratchpad port between the load port (P0) and the store-commit port (P1) using round-robin arbitration. Byte and halfword stores are converted into read-modify-write word sequences, because the scratchpad writes whole words only. Loads are returned with sub-word extraction. Misaligned, out-of-range and timed-out accesses are reported as errors.

## Interface
- `XLEN`, 32: data/address width.
- `MEM_SIZE`, 4096: scratchpad bytes; word index range is 0..MEM_SIZE/4-1.
- `TIMEOUT`, 16: maximum wait cycles for `sp_ready` before an error response.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `p0_req`, `p1_req`  in  1  request; held with its fields stable until the matching `pN_gnt`.
- `p0_we`, `p1_we`  in  1  1 = store, 0 = load.
- `p0_addr`, `p1_addr`  in  XLEN  byte address.
- `p0_wdata`, `p1_wdata`  in  XLEN  store data, right-aligned.
- `p0_size`, `p1_size`  in  2  00 = byte, 01 = half, 10 = word, 11 = invalid.
- `p0_gnt`, `p1_gnt`  out  1  combinational; request accepted this cycle.
- `p0_rvalid`, `p1_rvalid`  out  1  registered one-cycle completion pulse, for loads and stores.
- `p0_rdata`, `p1_rdata`  out  XLEN  registered load data, zero-extended; 0 for stores and errors.
- `p0_err`, `p1_err`  out  1  registered; valid with `rvalid`.
- `sp_req`, `sp_we`  out  1  scratchpad request and write enable.
- `sp_addr`  out  XLEN  always word-aligned ({addr[XLEN-1:2], 2'b00}).
- `sp_wdata`  out  XLEN  full word.
- `sp_size`  out  2  always 2'b10.
- `sp_ready`  in  1  scratchpad response pulse.
- `sp_rdata`  in  XLEN  scratchpad read data.

## Operation
- States: IDLE, RD, WAIT_RD, WR, WAIT_WR.
- `sp_*` outputs are decoded from the registered state:
  - `sp_req`=1 only in RD and WR.
  - `sp_we`=1 only in WR.
  - Each access drives `sp_req` for exactly one cycle.
- IDLE arbitration:
  - One requester: grant it.
  - Both requesting: grant the port not granted last. The last-grant pointer resets to P1, so P0 wins the first contention.
  - The granted request (port, we, addr, wdata, size) is latched at the edge.
- Error checks, made at grant:
  - size 11 → error.
  - half with addr[0]=1 → error.
  - word with addr[1:0]≠0 → error.
  - addr[XLEN-1:2] ≥ MEM_SIZE/4 → error.
  - On error: no scratchpad access, state stays IDLE, and the next cycle pulses rvalid with err=1 and rdata=0.
- Next state after a good grant:
  - Load → RD.
  - Word store → WR with `sp_wdata`=wdata.
  - Byte/half store → RD.
- WAIT_RD on `sp_ready`:
  - Load: register response with rdata = sp_rdata >> (8·addr[1:0]), masked to 8 bits (byte) or 16 bits (half), or the full word. Go to IDLE.
  - Sub-word store: merge wdata[7:0] or wdata[15:0] into the lane selected by addr[1:0] of the latched sp_rdata, keeping other bytes. Go to WR.
- WAIT_WR on `sp_ready`: register response with rvalid=1, err=0, rdata=0. Go to IDLE.
- Timeout: a counter clears on entry to a WAIT state. If it reaches TIMEOUT with no `sp_ready`, register rvalid=1, err=1, rdata=0 and go to IDLE. A late `sp_ready` in IDLE is ignored.
- `sp_ready` outside the WAIT states is ignored.
- Only one port's rvalid is ever high in a cycle.

## Timing
- Reset values:
  - State IDLE.
  - All `pN_rvalid`/`pN_rdata`/`pN_err` = 0.
  - `sp_req`/`sp_we` = 0; `sp_addr`/`sp_wdata` = 0; `sp_size` = 10.
  - Counter = 0.
  - Last-grant pointer = P1.
- Reset mid-operation aborts the access with no response. A store that reaches WR before reset may already be committed to the scratchpad.
- Latencies, counted from the gnt cycle (cycle 0) to rvalid:
  - Word load or word store: 3 (RD/WR at cycle 1, sp_ready at cycle 2, rvalid at cycle 3).
  - Sub-word store: 5.
  - Error at grant: 1.
- A new grant may occur in the same cycle as the previous rvalid, because the state is IDLE then. Back-to-back word accesses therefore sustain one access per 3 cycles.
- `pN_gnt` is high only in IDLE.

## Test plan
- Word store, then load: P1 stores 0xDEADBEEF to 0x10. Expect rvalid at gnt+3. P0 then loads 0x10: rdata=0xDEADBEEF, err=0, at gnt+3.
- Byte store RMW: word 0x10=0xDEADBEEF. P1 stores byte 0xAA at 0x12. Expect RD then WR with sp_wdata=0xDEAABEEF and rvalid at gnt+5. A byte load from 0x12 returns 0x000000AA; a half load from 0x12 returns 0x0000DEAA.
- Contention: p0_req and p1_req held high continuously from reset. Grants must go P0, P1, P0, P1, with each rvalid on the matching port only.
- Errors:
  - Word load at 0x6, half load at 0x3, size 11, or load at 0x1000 → rvalid+err at gnt+1, and `sp_req` never asserted.
- Timeout: tie `sp_ready`=0 for a word load. Expect err at WAIT_RD entry+TIMEOUT. A stray `sp_ready` afterwards causes no rvalid.
- Reset asserted in WAIT_RD: all outputs read 0 while reset is high. After release, a new P0 load completes normally at gnt+3.

Source files
------------

// File: rtl/dmem_port_arbiter_if.sv
// dmem_port_arbiter_if
// Bundles the two requester ports (P0 = load port, P1 = store-commit port)
// and the single scratchpad port of dmem_port_arbiter.
//   pN_req/we/addr/wdata/size : request fields from requester N
//   pN_gnt                    : request accepted this cycle
//   pN_rvalid/rdata/err       : completion pulse, load data, error flag
//   sp_req/we/addr/wdata/size : word access towards the scratchpad
//   sp_ready/sp_rdata         : scratchpad response pulse and read data
// Modport slave is the arbiter's view; modport master is the environment
// (requesters plus scratchpad).
interface dmem_port_arbiter_if #(
  parameter int XLEN = 32
);
  logic            p0_req;
  logic            p0_we;
  logic [XLEN-1:0] p0_addr;
  logic [XLEN-1:0] p0_wdata;
  logic [1:0]      p0_size;
  logic            p0_gnt;
  logic            p0_rvalid;
  logic [XLEN-1:0] p0_rdata;
  logic            p0_err;

  logic            p1_req;
  logic            p1_we;
  logic [XLEN-1:0] p1_addr;
  logic [XLEN-1:0] p1_wdata;
  logic [1:0]      p1_size;
  logic            p1_gnt;
  logic            p1_rvalid;
  logic [XLEN-1:0] p1_rdata;
  logic            p1_err;

  logic            sp_req;
  logic            sp_we;
  logic [XLEN-1:0] sp_addr;
  logic [XLEN-1:0] sp_wdata;
  logic [1:0]      sp_size;
  logic            sp_ready;
  logic [XLEN-1:0] sp_rdata;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata, p0_size,
    output p0_gnt, p0_rvalid, p0_rdata, p0_err,
    input  p1_req, p1_we, p1_addr, p1_wdata, p1_size,
    output p1_gnt, p1_rvalid, p1_rdata, p1_err,
    output sp_req, sp_we, sp_addr, sp_wdata, sp_size,
    input  sp_ready, sp_rdata
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata, p0_size,
    input  p0_gnt, p0_rvalid, p0_rdata, p0_err,
    output p1_req, p1_we, p1_addr, p1_wdata, p1_size,
    input  p1_gnt, p1_rvalid, p1_rdata, p1_err,
    input  sp_req, sp_we, sp_addr, sp_wdata, sp_size,
    output sp_ready, sp_rdata
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
// Shares one word-wide scratchpad port between the load port (P0) and the
// store-commit port (P1) with round-robin arbitration. Byte/half stores are
// turned into read-modify-write word sequences; loads return the selected
// lane zero-extended. Misaligned, out-of-range and timed-out accesses
// complete with err=1.
//   clk    : rising-edge clock
//   reset  : asynchronous, active-high
//   bus    : dmem_port_arbiter_if.slave (requester ports and scratchpad port)
module dmem_port_arbiter #(
  parameter int XLEN     = 32,
  parameter int MEM_SIZE = 4096,
  parameter int TIMEOUT  = 16
) (
  input logic                clk,
  input logic                reset,
  dmem_port_arbiter_if.slave bus
);

  typedef enum logic [2:0] {IDLE, RD, WAIT_RD, WR, WAIT_WR} state_t;

  localparam int              CW         = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]   LAST_WAIT  = CW'(TIMEOUT - 1);
  localparam logic [XLEN-1:0] WORD_COUNT = XLEN'(MEM_SIZE / 4);

  state_t          state;
  logic            last_p1;
  logic            cur_p1;
  logic            cur_we;
  logic [XLEN-1:0] cur_addr;
  logic [15:0]     cur_lane_data;
  logic [1:0]      cur_size;
  logic [CW-1:0]   wait_cnt;
  logic [XLEN-1:0] wdata_q;

  logic            p0_rvalid_q, p1_rvalid_q;
  logic            p0_err_q, p1_err_q;
  logic [XLEN-1:0] p0_rdata_q, p1_rdata_q;

  logic            idle, g0, g1, grant;
  logic            sel_we;
  logic [XLEN-1:0] sel_addr, sel_wdata;
  logic [1:0]      sel_size;
  logic            sel_err;
  logic            timed_out;

  logic [4:0]      lane_shift;
  logic [XLEN-1:0] size_mask, load_data, lane_mask, lane_data, merged;

  logic            rsp_fire, rsp_err, rsp_p1;
  logic [XLEN-1:0] rsp_data;

  // Grants are only possible in IDLE. On contention the port that did not
  // win last time gets the grant.
  assign idle  = (state == IDLE) && !reset;
  assign g0    = idle && bus.p0_req && (!bus.p1_req || last_p1);
  assign g1    = idle && bus.p1_req && (!bus.p0_req || !last_p1);
  assign grant = g0 || g1;

  assign sel_we    = g1 ? bus.p1_we    : bus.p0_we;
  assign sel_addr  = g1 ? bus.p1_addr  : bus.p0_addr;
  assign sel_wdata = g1 ? bus.p1_wdata : bus.p0_wdata;
  assign sel_size  = g1 ? bus.p1_size  : bus.p0_size;

  // Alignment and range check of the request being granted.
  always_comb begin
    sel_err = 1'b0;
    case (sel_size)
      2'b00:   sel_err = 1'b0;
      2'b01:   sel_err = sel_addr[0];
      2'b10:   sel_err = |sel_addr[1:0];
      default: sel_err = 1'b1;
    endcase
    if ({2'b00, sel_addr[XLEN-1:2]} >= WORD_COUNT) sel_err = 1'b1;
  end

  // Lane helpers: the same size mask serves both load extraction and the
  // store merge, so all sub-word handling keys off cur_size and addr[1:0].
  always_comb begin
    size_mask = '1;
    if (cur_size == 2'b00) size_mask = XLEN'(8'hFF);
    else if (cur_size == 2'b01) size_mask = XLEN'(16'hFFFF);
  end

  assign lane_shift = {cur_addr[1:0], 3'b000};
  assign load_data  = (bus.sp_rdata >> lane_shift) & size_mask;
  assign lane_mask  = size_mask << lane_shift;
  assign lane_data  = ({{(XLEN-16){1'b0}}, cur_lane_data} & size_mask) << lane_shift;
  assign merged     = (bus.sp_rdata & ~lane_mask) | lane_data;

  assign timed_out = (wait_cnt == LAST_WAIT);

  // Decide whether a completion is registered at the coming edge and for
  // which port. Errors detected at grant respond without any access.
  always_comb begin
    rsp_fire = 1'b0;
    rsp_err  = 1'b0;
    rsp_data = '0;
    rsp_p1   = cur_p1;
    case (state)
      IDLE: begin
        if (grant && sel_err) begin
          rsp_fire = 1'b1;
          rsp_err  = 1'b1;
          rsp_p1   = g1;
        end
      end
      WAIT_RD: begin
        if (bus.sp_ready) begin
          if (!cur_we) begin
            rsp_fire = 1'b1;
            rsp_data = load_data;
          end
        end else if (timed_out) begin
          rsp_fire = 1'b1;
          rsp_err  = 1'b1;
        end
      end
      WAIT_WR: begin
        if (bus.sp_ready) begin
          rsp_fire = 1'b1;
        end else if (timed_out) begin
          rsp_fire = 1'b1;
          rsp_err  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Access sequencer. The wait counter is cleared on every entry to a WAIT
  // state; a late sp_ready after a timeout lands in IDLE and is ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      last_p1       <= 1'b1;
      cur_p1        <= 1'b0;
      cur_we        <= 1'b0;
      cur_addr      <= '0;
      cur_lane_data <= '0;
      cur_size      <= 2'b00;
      wait_cnt      <= '0;
      wdata_q       <= '0;
      p0_rvalid_q   <= 1'b0;
      p1_rvalid_q   <= 1'b0;
      p0_err_q      <= 1'b0;
      p1_err_q      <= 1'b0;
      p0_rdata_q    <= '0;
      p1_rdata_q    <= '0;
    end else begin
      p0_rvalid_q <= rsp_fire && !rsp_p1;
      p1_rvalid_q <= rsp_fire && rsp_p1;
      p0_err_q    <= rsp_fire && !rsp_p1 && rsp_err;
      p1_err_q    <= rsp_fire && rsp_p1 && rsp_err;
      p0_rdata_q  <= (rsp_fire && !rsp_p1) ? rsp_data : '0;
      p1_rdata_q  <= (rsp_fire && rsp_p1) ? rsp_data : '0;

      case (state)
        IDLE: begin
          if (grant) begin
            last_p1       <= g1;
            cur_p1        <= g1;
            cur_we        <= sel_we;
            cur_addr      <= sel_addr;
            cur_lane_data <= sel_wdata[15:0];
            cur_size      <= sel_size;
            if (!sel_err) begin
              if (sel_we && sel_size == 2'b10) begin
                wdata_q <= sel_wdata;
                state   <= WR;
              end else begin
                state <= RD;
              end
            end
          end
        end
        RD: begin
          wait_cnt <= '0;
          state    <= WAIT_RD;
        end
        WR: begin
          wait_cnt <= '0;
          state    <= WAIT_WR;
        end
        WAIT_RD: begin
          if (bus.sp_ready) begin
            if (cur_we) begin
              wdata_q <= merged;
              state   <= WR;
            end else begin
              state <= IDLE;
            end
          end else if (timed_out) begin
            state <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        WAIT_WR: begin
          if (bus.sp_ready || timed_out) begin
            state <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.p0_gnt    = g0;
  assign bus.p1_gnt    = g1;
  assign bus.p0_rvalid = p0_rvalid_q;
  assign bus.p1_rvalid = p1_rvalid_q;
  assign bus.p0_err    = p0_err_q;
  assign bus.p1_err    = p1_err_q;
  assign bus.p0_rdata  = p0_rdata_q;
  assign bus.p1_rdata  = p1_rdata_q;

  assign bus.sp_req   = (state == RD) || (state == WR);
  assign bus.sp_we    = (state == WR);
  assign bus.sp_addr  = {cur_addr[XLEN-1:2], 2'b00};
  assign bus.sp_wdata = wdata_q;
  assign bus.sp_size  = 2'b10;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter
// Bench for dmem_port_arbiter: a word-array scratchpad that answers one
// cycle after each sp_req, a byte-array reference model for expected
// results, a directed vector table, randomized accesses and hand-written
// contention / timeout / reset sequences.
module tb_dmem_port_arbiter;

  localparam int XLEN     = 32;
  localparam int MEM_SIZE = 4096;
  localparam int TIMEOUT  = 16;

  logic clk;
  logic reset;
  logic sp_init;
  logic mute;
  logic stray_ready;
  logic mem_ready;
  logic [31:0] mem_rdata;
  logic [31:0] sp_mem [0:MEM_SIZE/4-1];
  logic [7:0]  ref_mem [0:MEM_SIZE-1];

  int n_checks;
  int n_fail;

  dmem_port_arbiter_if #(.XLEN(XLEN)) bus ();

  dmem_port_arbiter #(.XLEN(XLEN), .MEM_SIZE(MEM_SIZE), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.sp_ready = mem_ready | stray_ready;
  assign bus.sp_rdata = mem_rdata;

  // Scratchpad: sees sp_req at an edge and answers during the next cycle.
  always @(posedge clk) begin
    if (sp_init) begin
      for (int i = 0; i < MEM_SIZE/4; i++) sp_mem[i] <= '0;
      mem_ready <= 1'b0;
      mem_rdata <= '0;
    end else if (reset) begin
      mem_ready <= 1'b0;
    end else begin
      mem_ready <= 1'b0;
      if (bus.sp_req && !mute) begin
        if (bus.sp_we) sp_mem[bus.sp_addr[11:2]] <= bus.sp_wdata;
        mem_rdata <= sp_mem[bus.sp_addr[11:2]];
        mem_ready <= 1'b1;
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, got, exp);
    end
  endtask

  function automatic logic gnt_of(input int p);
    return (p == 1) ? bus.p1_gnt : bus.p0_gnt;
  endfunction

  function automatic logic rvalid_of(input int p);
    return (p == 1) ? bus.p1_rvalid : bus.p0_rvalid;
  endfunction

  task automatic drive_port(input int p, input logic req, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [1:0] size);
    if (p == 1) begin
      bus.p1_req = req; bus.p1_we = we; bus.p1_addr = addr; bus.p1_wdata = wdata; bus.p1_size = size;
    end else begin
      bus.p0_req = req; bus.p0_we = we; bus.p0_addr = addr; bus.p0_wdata = wdata; bus.p0_size = size;
    end
  endtask

  // Reference model: byte-addressed little-endian memory and the access rules.
  task automatic model_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [1:0] size, output logic exp_err,
                              output logic [31:0] exp_data, output int exp_lat);
    int n;
    exp_err  = (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) ||
               (size == 2'd2 && addr % 4 != 0) || (addr >= MEM_SIZE);
    exp_data = 0;
    exp_lat  = 1;
    if (!exp_err) begin
      n = 1 << size;
      if (we) begin
        for (int i = 0; i < n; i++) ref_mem[addr + i] = wdata[8*i +: 8];
        exp_lat = (n == 4) ? 3 : 5;
      end else begin
        for (int i = 0; i < n; i++) exp_data = exp_data | (32'(ref_mem[addr + i]) << (8*i));
        exp_lat = 3;
      end
    end
  endtask

  // One access on one port: wait for gnt, drop the request, wait for rvalid.
  task automatic apply_stimulus(input int port, input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [1:0] size, input int max_wait,
                                output logic got_err, output logic [31:0] got_data, output int got_lat,
                                output logic saw_req, output logic [31:0] seen_addr,
                                output logic [31:0] seen_wr, output logic wrong_port);
    int waited;
    got_err = 0; got_data = 0; got_lat = 0; saw_req = 0;
    seen_addr = 0; seen_wr = 0; wrong_port = 0;
    @(negedge clk);
    drive_port(port, 1'b1, we, addr, wdata, size);
    #1;
    waited = 0;
    while (!gnt_of(port) && waited < 20) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!gnt_of(port)) begin
      check_output("grant_timeout", 32'(gnt_of(port)), 32'd1);
      drive_port(port, 1'b0, we, addr, wdata, size);
      return;
    end
    for (int k = 1; k <= max_wait; k++) begin
      @(negedge clk);
      if (k == 1) drive_port(port, 1'b0, we, addr, wdata, size);
      #1;
      if (bus.sp_req) begin
        saw_req   = 1;
        seen_addr = bus.sp_addr;
        if (bus.sp_we) seen_wr = bus.sp_wdata;
      end
      if (rvalid_of(1 - port)) wrong_port = 1;
      if (rvalid_of(port)) begin
        got_err  = (port == 1) ? bus.p1_err : bus.p0_err;
        got_data = (port == 1) ? bus.p1_rdata : bus.p0_rdata;
        got_lat  = k;
        break;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_p0_rvalid"}, 32'(bus.p0_rvalid), 0);
    check_output({tag, "_p1_rvalid"}, 32'(bus.p1_rvalid), 0);
    check_output({tag, "_p0_rdata"}, bus.p0_rdata, 0);
    check_output({tag, "_p1_rdata"}, bus.p1_rdata, 0);
    check_output({tag, "_p0_err"}, 32'(bus.p0_err), 0);
    check_output({tag, "_p1_err"}, 32'(bus.p1_err), 0);
    check_output({tag, "_sp_req"}, 32'(bus.sp_req), 0);
    check_output({tag, "_sp_we"}, 32'(bus.sp_we), 0);
    check_output({tag, "_sp_addr"}, bus.sp_addr, 0);
    check_output({tag, "_sp_wdata"}, bus.sp_wdata, 0);
    check_output({tag, "_sp_size"}, 32'(bus.sp_size), 32'd2);
  endtask

  typedef struct {
    int          port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        exp_err;
    logic [31:0] exp_data;
    int          exp_lat;
    logic        chk_wr;
    logic [31:0] exp_wr;
  } vec_t;

  initial begin
    vec_t        vecs[$];
    logic        got_err, saw_req, wrong_port, m_err;
    logic [31:0] got_data, seen_addr, seen_wr, m_data, exp0, exp1;
    int          got_lat, m_lat;
    string       nm;

    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < MEM_SIZE; i++) ref_mem[i] = 8'h00;

    vecs.push_back('{1, 1'b1, 32'h010, 32'hDEADBEEF, 2'd2, 1'b0, 32'h0,        3, 1'b1, 32'hDEADBEEF});
    vecs.push_back('{0, 1'b0, 32'h010, 32'h0,        2'd2, 1'b0, 32'hDEADBEEF, 3, 1'b0, 32'h0});
    vecs.push_back('{1, 1'b1, 32'h012, 32'h000000AA, 2'd0, 1'b0, 32'h0,        5, 1'b1, 32'hDEAABEEF});
    vecs.push_back('{0, 1'b0, 32'h012, 32'h0,        2'd0, 1'b0, 32'h000000AA, 3, 1'b0, 32'h0});
    vecs.push_back('{0, 1'b0, 32'h012, 32'h0,        2'd1, 1'b0, 32'h0000DEAA, 3, 1'b0, 32'h0});
    vecs.push_back('{1, 1'b1, 32'h010, 32'hFFFF1234, 2'd1, 1'b0, 32'h0,        5, 1'b1, 32'hDEAA1234});
    vecs.push_back('{0, 1'b0, 32'h011, 32'h0,        2'd0, 1'b0, 32'h00000012, 3, 1'b0, 32'h0});
    vecs.push_back('{1, 1'b0, 32'h010, 32'h0,        2'd2, 1'b0, 32'hDEAA1234, 3, 1'b0, 32'h0});
    vecs.push_back('{0, 1'b0, 32'h006, 32'h0,        2'd2, 1'b1, 32'h0,        1, 1'b0, 32'h0});
    vecs.push_back('{0, 1'b0, 32'h003, 32'h0,        2'd1, 1'b1, 32'h0,        1, 1'b0, 32'h0});
    vecs.push_back('{1, 1'b0, 32'h020, 32'h0,        2'd3, 1'b1, 32'h0,        1, 1'b0, 32'h0});
    vecs.push_back('{0, 1'b0, 32'h1000, 32'h0,       2'd2, 1'b1, 32'h0,        1, 1'b0, 32'h0});
    vecs.push_back('{1, 1'b1, 32'h1000, 32'h11111111, 2'd2, 1'b1, 32'h0,       1, 1'b0, 32'h0});
    vecs.push_back('{1, 1'b1, 32'hFFC, 32'h12345678, 2'd2, 1'b0, 32'h0,        3, 1'b1, 32'h12345678});
    vecs.push_back('{0, 1'b0, 32'hFFF, 32'h0,        2'd0, 1'b0, 32'h00000012, 3, 1'b0, 32'h0});
    vecs.push_back('{0, 1'b0, 32'hFFE, 32'h0,        2'd1, 1'b0, 32'h00001234, 3, 1'b0, 32'h0});
    vecs.push_back('{1, 1'b1, 32'h017, 32'h00000055, 2'd0, 1'b0, 32'h0,        5, 1'b1, 32'h55000000});
    vecs.push_back('{0, 1'b0, 32'h014, 32'h0,        2'd2, 1'b0, 32'h55000000, 3, 1'b0, 32'h0});

    reset = 1'b1; sp_init = 1'b1; mute = 1'b0; stray_ready = 1'b0;
    drive_port(0, 1'b0, 1'b0, 0, 0, 2'd2);
    drive_port(1, 1'b0, 1'b0, 0, 0, 2'd2);
    repeat (2) @(posedge clk);
    @(negedge clk);
    sp_init = 1'b0;
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    reset = 1'b0;

    // Directed vector table.
    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].size, 30,
                     got_err, got_data, got_lat, saw_req, seen_addr, seen_wr, wrong_port);
      model_access(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].size, m_err, m_data, m_lat);
      nm = $sformatf("vec%0d", i);
      check_output({nm, "_err"}, 32'(got_err), 32'(vecs[i].exp_err));
      check_output({nm, "_rdata"}, got_data, vecs[i].exp_data);
      check_output({nm, "_latency"}, 32'(got_lat), 32'(vecs[i].exp_lat));
      check_output({nm, "_sp_req_seen"}, 32'(saw_req), 32'(!vecs[i].exp_err));
      check_output({nm, "_other_port_rvalid"}, 32'(wrong_port), 0);
      if (!vecs[i].exp_err)
        check_output({nm, "_sp_addr"}, seen_addr, {vecs[i].addr[31:2], 2'b00});
      if (vecs[i].chk_wr)
        check_output({nm, "_sp_wdata"}, seen_wr, vecs[i].exp_wr);
    end

    // Randomized accesses against the reference model.
    for (int i = 0; i < 120; i++) begin
      int          port, r;
      logic        we;
      logic [31:0] addr, wdata;
      logic [1:0]  size;
      port  = int'($urandom_range(0, 1));
      we    = 1'($urandom_range(0, 1));
      wdata = $urandom;
      r     = int'($urandom_range(0, 15));
      size  = (r == 0) ? 2'd3 : 2'(r % 3);
      r     = int'($urandom_range(0, 9));
      if (r == 0)      addr = 32'h1000 + $urandom_range(0, 255);
      else if (r == 1) addr = 32'hFF8 + $urandom_range(0, 7);
      else             addr = $urandom_range(0, 47);
      apply_stimulus(port, we, addr, wdata, size, 30,
                     got_err, got_data, got_lat, saw_req, seen_addr, seen_wr, wrong_port);
      model_access(we, addr, wdata, size, m_err, m_data, m_lat);
      nm = $sformatf("rand%0d_p%0d_we%0d_a%08h_s%0d", i, port, we, addr, size);
      check_output({nm, "_err"}, 32'(got_err), 32'(m_err));
      check_output({nm, "_rdata"}, got_data, m_data);
      check_output({nm, "_latency"}, 32'(got_lat), 32'(m_lat));
    end

    // Contention: both ports request continuously from reset.
    begin
      int   grants[$], pending[$], gcyc[$];
      logic both_gnt, port_err, data_err, spacing_err;
      logic [3:0] seq;
      model_access(1'b0, 32'h010, 0, 2'd2, m_err, exp0, m_lat);
      model_access(1'b0, 32'hFFC, 0, 2'd2, m_err, exp1, m_lat);
      both_gnt = 0; port_err = 0; data_err = 0; spacing_err = 0;
      @(negedge clk);
      reset = 1'b1;
      drive_port(0, 1'b1, 1'b0, 32'h010, 0, 2'd2);
      drive_port(1, 1'b1, 1'b0, 32'hFFC, 0, 2'd2);
      @(negedge clk);
      reset = 1'b0;
      for (int c = 0; c < 20; c++) begin
        if (c == 15) begin
          drive_port(0, 1'b0, 1'b0, 32'h010, 0, 2'd2);
          drive_port(1, 1'b0, 1'b0, 32'hFFC, 0, 2'd2);
        end
        #1;
        if (bus.p0_rvalid && bus.p1_rvalid) port_err = 1;
        if (bus.p0_rvalid) begin
          if (pending.size() == 0 || pending.pop_front() != 0) port_err = 1;
          if (bus.p0_rdata !== exp0 || bus.p0_err) data_err = 1;
        end else if (bus.p1_rvalid) begin
          if (pending.size() == 0 || pending.pop_front() != 1) port_err = 1;
          if (bus.p1_rdata !== exp1 || bus.p1_err) data_err = 1;
        end
        if (bus.p0_gnt && bus.p1_gnt) both_gnt = 1;
        if (bus.p0_gnt) begin grants.push_back(0); pending.push_back(0); gcyc.push_back(c); end
        if (bus.p1_gnt) begin grants.push_back(1); pending.push_back(1); gcyc.push_back(c); end
        @(negedge clk);
      end
      for (int g = 1; g < gcyc.size(); g++) if (gcyc[g] - gcyc[g-1] != 3) spacing_err = 1;
      seq = (grants.size() >= 4) ?
            {grants[0][0], grants[1][0], grants[2][0], grants[3][0]} : 4'hF;
      check_output("contention_order", 32'(seq), 32'b0101);
      check_output("contention_grant_count", 32'(grants.size()), 32'd5);
      check_output("contention_both_gnt", 32'(both_gnt), 0);
      check_output("contention_rvalid_port", 32'(port_err), 0);
      check_output("contention_rdata", 32'(data_err), 0);
      check_output("contention_grant_spacing", 32'(spacing_err), 0);
      check_output("contention_unanswered", 32'(pending.size()), 0);
    end

    // Timeout: scratchpad never answers a word load.
    mute = 1'b1;
    apply_stimulus(0, 1'b0, 32'h010, 0, 2'd2, 40,
                   got_err, got_data, got_lat, saw_req, seen_addr, seen_wr, wrong_port);
    check_output("timeout_err", 32'(got_err), 1);
    check_output("timeout_rdata", got_data, 0);
    check_output("timeout_latency", 32'(got_lat), 32'(2 + TIMEOUT));
    check_output("timeout_other_port_rvalid", 32'(wrong_port), 0);
    begin
      logic stray_resp;
      stray_resp = 0;
      @(negedge clk);
      stray_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
        #1;
        if (bus.p0_rvalid || bus.p1_rvalid) stray_resp = 1;
        @(negedge clk);
        stray_ready = 1'b0;
      end
      check_output("stray_ready_rvalid", 32'(stray_resp), 0);
    end

    // Reset while waiting in WAIT_RD aborts the access silently.
    begin
      logic late_resp;
      late_resp = 0;
      @(negedge clk);
      drive_port(0, 1'b1, 1'b0, 32'h014, 0, 2'd2);
      #1;
      check_output("abort_gnt", 32'(bus.p0_gnt), 1);
      @(negedge clk);
      drive_port(0, 1'b0, 1'b0, 32'h014, 0, 2'd2);
      #1;
      check_output("abort_rd_sp_req", 32'(bus.sp_req), 1);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check_reset_outputs("abort");
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      mute  = 1'b0;
      for (int c = 0; c < 4; c++) begin
        #1;
        if (bus.p0_rvalid || bus.p1_rvalid) late_resp = 1;
        @(negedge clk);
      end
      check_output("abort_no_response", 32'(late_resp), 0);
      model_access(1'b0, 32'h010, 0, 2'd2, m_err, m_data, m_lat);
      apply_stimulus(0, 1'b0, 32'h010, 0, 2'd2, 30,
                     got_err, got_data, got_lat, saw_req, seen_addr, seen_wr, wrong_port);
      check_output("after_reset_err", 32'(got_err), 0);
      check_output("after_reset_rdata", got_data, m_data);
      check_output("after_reset_latency", 32'(got_lat), 3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
